dram_ctrl: RTL and testbench
============================

Name: dram_ctrl

Overview:
Host-side controller and initiator for the 8x4 DRAM memory model. It accepts single-word read/write requests over a valid/ready handshake and drives the model's address, active-low write-enable and shared bidirectional data bus. It also schedules periodic refresh sweeps, reading each row and writing it back. It sits between a host (or bench sequencer) and the DRAM model, which is the responder on this interface.

Parameters:
ADDR_WIDTH, 3, row address width; memory depth = 2**ADDR_WIDTH
DATA_WIDTH, 4, data word width
READ_LATENCY, 1, cycles mem_addr is held with mem_we=1 before read data is sampled; legal range >=1
REFRESH_INTERVAL, 64, cycles between refresh requests; legal range > 2**ADDR_WIDTH*(READ_LATENCY+1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  host request present
req_ready  out  1  controller can accept a request this cycle
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read data
rsp_rdata  out  DATA_WIDTH  read data
refresh_busy  out  1  refresh sweep in progress
mem_addr  out  ADDR_WIDTH  DRAM address
mem_we  out  1  DRAM write enable, active low (0=write, 1=read)
mem_data  inout  DATA_WIDTH  DRAM shared data bus

Behaviour:
- Reset (async, immediate): state IDLE; mem_we=1; mem_addr=0; mem_data released (high-Z); rsp_valid=0; rsp_rdata=0; refresh_busy=0; refresh counter=0; refresh_pending=0. After reset, req_ready=1.
- Bus rule: mem_data is driven only while mem_we=0 and is high-Z in every other cycle. The bus is never driven while mem_we=1.
- req_ready = (state==IDLE) && !refresh_pending. A transfer occurs on a rising edge where req_valid && req_ready. Request fields are captured on that edge.
- States: IDLE, WR, RD, REF_RD, REF_WR.
- IDLE -> WR on an accepted write. IDLE -> RD on an accepted read. IDLE -> REF_RD when refresh_pending is set; refresh has priority over a simultaneous req_valid.
- WR: lasts 1 cycle. mem_we=0, mem_addr=captured addr, mem_data=captured wdata. The DRAM captures the word on the edge that ends WR. Next state is IDLE.
- RD: lasts READ_LATENCY cycles. mem_we=1, mem_addr held, bus high-Z. On the final RD edge, mem_data is sampled into rsp_rdata. rsp_valid=1 for exactly the following cycle. Next state is IDLE.
- Read latency: rsp_valid asserts READ_LATENCY cycles after the acceptance edge.
- Back-to-back: a new request may be accepted in the cycle rsp_valid is high. Sustained writes are accepted every 2 cycles. Sustained reads are accepted every READ_LATENCY+1 cycles.
- Refresh counter: free-running in every state. On reaching REFRESH_INTERVAL-1 it wraps to 0 and sets refresh_pending (sticky). refresh_pending clears on entry to REF_RD for row 0.
- Refresh sweep: row index r runs from 0 to 2**ADDR_WIDTH-1. For each row:
  - REF_RD: READ_LATENCY cycles, mem_we=1, mem_addr=r; data is sampled into an internal holding register.
  - REF_WR: 1 cycle, mem_we=0, mem_addr=r, mem_data=holding register.
  - After the last row, the next state is IDLE.
- Sweep length is 2**ADDR_WIDTH*(READ_LATENCY+1) cycles; 16 cycles at default parameters.
- refresh_busy=1 throughout REF_RD/REF_WR. rsp_valid is never asserted by a refresh. Refresh never alters stored contents.
- A refresh that becomes pending mid-transaction waits until the transaction completes and the state returns to IDLE. It then takes priority on that IDLE cycle.
- Reset asserted mid-transaction or mid-sweep aborts it immediately: the bus is released, mem_we=1, and no rsp_valid pulse follows.
- Address arithmetic: the refresh row index wraps modulo 2**ADDR_WIDTH. Host addresses are used unmodified.

Test Plan:
- Write 0..7 to addresses 0..7, then read 0..7 (defaults) -> each read returns rsp_rdata=address value. rsp_valid is high exactly 1 cycle after each read-acceptance edge. mem_we=0 for exactly one cycle per write.
- Hold req_valid high with 4 writes then 4 reads queued -> req_ready deasserts in WR/RD cycles. Writes are accepted every 2 cycles, reads every 2 cycles, with no request lost or duplicated.
- REFRESH_INTERVAL=32, memory preloaded with 0xF-addr -> refresh_busy high 16 cycles. mem_addr sweeps 0..7 with alternating mem_we 1/0. A subsequent full readback returns 0xF-addr.
- refresh_pending and req_valid coincide in IDLE -> refresh wins; req_ready=0 for the sweep. The held request is accepted on the first IDLE cycle after refresh_busy falls.
- Assert rst mid-read and mid-refresh -> mem_data high-Z and mem_we=1 in the same timestep, no rsp_valid, req_ready=1 after release.
- Bus checker over all scenarios -> mem_data is never driven by the controller while mem_we=1, and never high-Z while mem_we=0.

Source files
------------

// File: rtl/dram_ctrl.sv
// -----------------------------------------------------------------------------
// dram_ctrl
// Host-side controller for a small DRAM model. Accepts single-word read/write
// requests on a valid/ready handshake, drives the DRAM address, active-low
// write enable and shared data bus, and periodically sweeps every row
// (read, then write back) to refresh it.
//
// Ports
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   req_valid     : host request present
//   req_ready     : controller accepts a request this cycle
//   req_write     : 1 = write, 0 = read
//   req_addr      : request address
//   req_wdata     : write data
//   rsp_valid     : one-cycle pulse, rsp_rdata holds read data
//   rsp_rdata     : read data
//   refresh_busy  : refresh sweep in progress
//   mem_addr      : DRAM address
//   mem_we        : DRAM write enable, active low
//   mem_data      : DRAM shared data bus (driven only while mem_we = 0)
// -----------------------------------------------------------------------------
module dram_ctrl #(
    parameter int ADDR_WIDTH       = 3,
    parameter int DATA_WIDTH       = 4,
    parameter int READ_LATENCY     = 1,
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  refresh_busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(READ_LATENCY - 1);
    localparam logic [LAT_W-1:0]      LAT_ONE  = LAT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ROW_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD     = 3'd2,
        ST_REF_RD = 3'd3,
        ST_REF_WR = 3'd4
    } state_e;

    state_e                state_q,     state_d;
    logic [LAT_W-1:0]      lat_q,       lat_d;
    logic [ADDR_WIDTH-1:0] row_q,       row_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    // Write data for host writes, holding register for refresh write-back.
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic [CNT_W-1:0]      ref_cnt_q,   ref_cnt_d;
    logic                  ref_pend_q,  ref_pend_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  busy_q,      busy_d;
    logic                  we_q,        we_d;
    logic                  pend_set_s;
    logic                  pend_clr_s;

    assign req_ready    = (state_q == ST_IDLE) && !ref_pend_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign refresh_busy = busy_q;
    assign mem_addr     = addr_q;
    assign mem_we       = we_q;
    // Bus ownership follows the registered write enable, so the bus can never
    // be driven while mem_we is high.
    assign mem_data     = we_q ? {DATA_WIDTH{1'bz}} : data_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        row_d       = row_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        pend_clr_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ref_pend_q) begin
                    // Refresh wins over any simultaneous host request.
                    state_d    = ST_REF_RD;
                    row_d      = {ADDR_WIDTH{1'b0}};
                    addr_d     = {ADDR_WIDTH{1'b0}};
                    lat_d      = {LAT_W{1'b0}};
                    pend_clr_s = 1'b1;
                end else if (req_valid && req_ready) begin
                    addr_d = req_addr;
                    lat_d  = {LAT_W{1'b0}};
                    if (req_write) begin
                        state_d = ST_WR;
                        data_d  = req_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD: begin
                if (lat_q == LAT_LAST) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_data;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end
            ST_REF_RD: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_REF_WR;
                    data_d  = mem_data;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end
            ST_REF_WR: begin
                if (row_q == ROW_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REF_RD;
                    row_d   = row_q + ROW_ONE;
                    addr_d  = row_q + ROW_ONE;
                    lat_d   = {LAT_W{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Free-running refresh timer; the pending flag is sticky until the
        // sweep actually starts.
        if (ref_cnt_q == CNT_LAST) begin
            ref_cnt_d  = {CNT_W{1'b0}};
            pend_set_s = 1'b1;
        end else begin
            ref_cnt_d  = ref_cnt_q + CNT_ONE;
            pend_set_s = 1'b0;
        end

        if (pend_set_s) begin
            ref_pend_d = 1'b1;
        end else if (pend_clr_s) begin
            ref_pend_d = 1'b0;
        end else begin
            ref_pend_d = ref_pend_q;
        end

        we_d   = !((state_d == ST_WR) || (state_d == ST_REF_WR));
        busy_d = (state_d == ST_REF_RD) || (state_d == ST_REF_WR);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= {LAT_W{1'b0}};
            row_q       <= {ADDR_WIDTH{1'b0}};
            addr_q      <= {ADDR_WIDTH{1'b0}};
            data_q      <= {DATA_WIDTH{1'b0}};
            ref_cnt_q   <= {CNT_W{1'b0}};
            ref_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            we_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_pend_q  <= ref_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            we_q        <= we_d;
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dram_ctrl
// Self-checking bench for dram_ctrl. Contains a behavioural DRAM responder,
// a reference memory image, and a negedge monitor that checks the bus rule,
// response timing/data, refresh sweep shape and handshake behaviour.
// -----------------------------------------------------------------------------
module tb_dram_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int L     = 1;
    localparam int RI    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int SWEEP = DEPTH * (L + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          refresh_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    wire  [DW-1:0] mem_data;

    logic          mem_clr;
    logic [DW-1:0] dram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int passed = 0;
    int total  = 0;
    int k;
    int host_we_low = 0;
    int ref_done    = 0;
    int acc_k   [$];
    bit acc_ref [$];
    bit acc_w   [$];
    int acc_a   [$];

    dram_ctrl #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .READ_LATENCY    (L),
        .REFRESH_INTERVAL(RI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .refresh_busy(refresh_busy),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    // DRAM responder: drives stored word while mem_we is high, stores on edge while low.
    assign mem_data = mem_we ? dram[mem_addr] : {DW{1'bz}};

    // DRAM storage update.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) dram[i] <= '0;
        end else if (mem_we == 1'b0) begin
            dram[mem_addr] <= mem_data;
        end
    end

    // Edge counter since last reset release (matches refresh timer phase).
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    // Monitor: reference model of observable behaviour, sampled at negedge.
    initial begin : monitor
        int       busy_len;
        int       rsp_due;
        int       ph;
        logic [DW-1:0] rsp_exp;
        bit       last_acc;
        bit       ref_since;
        busy_len  = 0;
        rsp_due   = -1;
        rsp_exp   = '0;
        last_acc  = 1'b0;
        ref_since = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || mem_clr) begin
                busy_len  = 0;
                rsp_due   = -1;
                last_acc  = 1'b0;
                ref_since = 1'b0;
                if (mem_clr) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end else begin
                // Bus ownership: controller value when writing, responder value otherwise.
                if (mem_we === 1'b0) begin
                    chk("bus_driven_we0", mem_data, ref_mem[mem_addr]);
                    if (!refresh_busy) host_we_low++;
                end else begin
                    chk("bus_free_we1", mem_data, dram[mem_addr]);
                end
                // Response timing and data.
                if (k == rsp_due) begin
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_rdata", rsp_rdata, rsp_exp);
                    rsp_due = -1;
                end else begin
                    chk("rsp_quiet", rsp_valid, 0);
                end
                if (last_acc) chk("ready_low_in_xfer", req_ready, 0);
                // Refresh sweep shape.
                if (refresh_busy) begin
                    if (busy_len == 0) begin
                        ph = k % RI;
                        chk("ref_start_phase", 32'(ph >= 1 && ph <= 1 + L), 32'd1);
                    end
                    chk("ref_addr", mem_addr, busy_len / (L + 1));
                    chk("ref_we", mem_we, ((busy_len % (L + 1)) == L) ? 0 : 1);
                    chk("ref_ready_low", req_ready, 0);
                    busy_len++;
                end else begin
                    if (busy_len != 0) begin
                        chk("ref_len", busy_len, SWEEP);
                        ref_done++;
                        ref_since = 1'b1;
                    end
                    busy_len = 0;
                end
                if (k > 0 && (k % RI) == 0) chk("ref_priority", req_ready, 0);
                // Acceptance bookkeeping.
                last_acc = 1'b0;
                if (req_valid && req_ready) begin
                    acc_k.push_back(k);
                    acc_ref.push_back(ref_since);
                    acc_w.push_back(req_write);
                    acc_a.push_back(int'(req_addr));
                    ref_since = 1'b0;
                    last_acc  = 1'b1;
                    if (req_write) begin
                        ref_mem[req_addr] = req_wdata;
                    end else begin
                        rsp_due = k + L + 1;
                        rsp_exp = ref_mem[req_addr];
                    end
                end
            end
        end
    end

    initial begin : stim
        bit            sw [8];
        logic [AW-1:0] sa [8];
        logic [DW-1:0] sd [8];
        int            base;
        int            n;
        int            r0;
        int            gap;
        rst       = 1'b1;
        mem_clr   = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        idle(3);

        // Reset state.
        chk("rst_mem_we", mem_we, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", refresh_busy, 0);
        chk("rst_ready", req_ready, 1);
        mem_clr = 1'b0;
        rst     = 1'b0;

        // Write a = a, then read back.
        for (int a = 0; a < DEPTH; a++) do_req(1'b1, AW'(a), DW'(a), 1'b0);
        idle(2);
        chk("we_low_per_write", host_we_low, DEPTH);
        for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), '0, 1'b0);
        idle(3);

        // Streamed 4 writes then 4 reads with valid held.
        for (int i = 0; i < 4; i++) begin
            sw[i] = 1'b1; sa[i] = AW'($urandom_range(0, DEPTH - 1)); sd[i] = DW'($urandom_range(0, 15));
        end
        for (int i = 4; i < 8; i++) begin
            sw[i] = 1'b0; sa[i] = sa[i-4]; sd[i] = '0;
        end
        base = acc_k.size();
        for (int i = 0; i < 8; i++) do_req(sw[i], sa[i], sd[i], i != 7);
        chk("stream_count", acc_k.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk("stream_kind", acc_w[base+i], sw[i]);
            chk("stream_addr", acc_a[base+i], sa[i]);
            if (i > 0) begin
                gap = (sw[i-1] ? 2 : L + 1) + (acc_ref[base+i] ? SWEEP + 1 : 0);
                chk("stream_gap", acc_k[base+i] - acc_k[base+i-1], gap);
            end
        end
        idle(3);

        // Preload 0xF-addr, let a refresh sweep run, then read everything back.
        for (int a = 0; a < DEPTH; a++) do_req(1'b1, AW'(a), DW'(15 - a), 1'b0);
        r0 = ref_done;
        n  = 0;
        while (ref_done == r0 && n < 200) begin @(negedge clk); n++; end
        chk("refresh_occurred", 32'(ref_done > r0), 32'd1);
        idle(1);
        for (int a = 0; a < DEPTH; a++) chk("refresh_keeps_data", dram[a], 15 - a);
        for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), '0, 1'b0);
        idle(2);

        // Request arriving exactly when refresh becomes pending.
        n = 0;
        do begin @(posedge clk); #1; n++; end while ((k % RI) != 0 && n < 100);
        base = k;
        r0   = ref_done;
        do_req(1'b1, 3'd3, 4'd9, 1'b0);
        chk("held_accept_time", acc_k[$], base + 1 + SWEEP);
        chk("held_after_refresh", ref_done - r0, 1);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                   DW'($urandom_range(0, 15)), 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(3);

        // Reset in the middle of a read.
        do_req(1'b0, 3'd5, '0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstrd_mem_we", mem_we, 1);
        chk("rstrd_rsp_valid", rsp_valid, 0);
        chk("rstrd_bus_free", mem_data, dram[mem_addr]);
        chk("rstrd_ready", req_ready, 1);
        idle(1);
        rst = 1'b0;
        idle(4);
        chk("rstrd_ready_after", req_ready, 1);

        // Reset in the middle of a refresh sweep.
        n = 0;
        while (!refresh_busy && n < 100) begin @(negedge clk); n++; end
        chk("sweep_started", refresh_busy, 1);
        idle(5);
        rst = 1'b1;
        #1;
        chk("rstref_mem_we", mem_we, 1);
        chk("rstref_busy", refresh_busy, 0);
        chk("rstref_bus_free", mem_data, dram[mem_addr]);
        idle(1);
        rst = 1'b0;
        #1;
        chk("rstref_ready", req_ready, 1);
        for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), '0, 1'b0);
        idle(4);

        for (int a = 0; a < DEPTH; a++) chk("final_contents", dram[a], ref_mem[a]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
